// File: rtl/systolic_array_pkg.sv
// Shared types and defaults for the systolic MAC arrays.
// word_t is kept unchanged for existing users of the fixed-N array.
package systolic_array_pkg;

  localparam int SA_DATA_W = 16;
  localparam int SA_ACC_W  = 32;

  typedef logic        [SA_DATA_W-1:0] word_t;
  typedef logic signed [SA_DATA_W-1:0] sdata_t;
  typedef logic signed [SA_ACC_W-1:0]  acc_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DRAIN  = 2'd3
  } sa_state_t;

  // Index width that stays legal for a single-entry dimension.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/skewed_systolic_array_mac_pe.sv
// One processing element: registered x/w/valid pass-through and a signed
// multiply-accumulate with enable and synchronous clear.
module mac_pe
  import systolic_array_pkg::*;
#(
  parameter int DATA_W = SA_DATA_W,
  parameter int ACC_W  = SA_ACC_W
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     i_en,
  input  logic                     i_clr,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [DATA_W-1:0] i_w,
  input  logic                     i_valid,
  output logic signed [DATA_W-1:0] o_x,
  output logic signed [DATA_W-1:0] o_w,
  output logic                     o_valid,
  output logic signed [ACC_W-1:0]  o_psum
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [DATA_W-1:0]   r_x;
  logic signed [DATA_W-1:0]   r_w;
  logic                       r_valid;
  logic signed [ACC_W-1:0]    r_psum;

  // Full-width signed product, sign-extended; the sum wraps modulo 2^ACC_W.
  assign w_prod     = i_x * i_w;
  assign w_prod_ext = ACC_W'(w_prod);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_x     <= '0;
      r_w     <= '0;
      r_valid <= 1'b0;
      r_psum  <= '0;
    end else begin
      if (i_en) begin
        r_x     <= i_x;
        r_w     <= i_w;
        r_valid <= i_valid;
      end
      if (i_clr) begin
        r_psum <= '0;
      end else if (i_en && i_valid) begin
        r_psum <= r_psum + w_prod_ext;
      end
    end
  end

  assign o_x     = r_x;
  assign o_w     = r_w;
  assign o_valid = r_valid;
  assign o_psum  = r_psum;

endmodule

// File: rtl/skewed_systolic_array.sv
// Output-stationary ROWS x COLS MAC array with internal input skew,
// valid/ready operand streaming and a row-serial result drain.
//
// state  | meaning
// IDLE   | waiting for start; psums hold for optional accumulation
// STREAM | accepting K operand vectors (in_ready=1)
// FLUSH  | ROWS+COLS-1 cycles letting the skewed wavefront finish
// DRAIN  | presenting psum rows 0..ROWS-1 on y_out with backpressure
module skewed_systolic_array
  import systolic_array_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = SA_DATA_W,
  parameter int ACC_W  = SA_ACC_W,
  parameter int K_MAX  = 256
) (
  input  logic                                  clk,
  input  logic                                  n_rst,
  input  logic                                  start,
  input  logic [$clog2(K_MAX+1)-1:0]            k_len,
  input  logic                                  accumulate,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [ROWS*DATA_W-1:0]                x_in,
  input  logic [COLS*DATA_W-1:0]                w_in,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
  output logic [COLS*ACC_W-1:0]                 y_out,
  output logic                                  busy,
  output logic                                  done
);

  localparam int K_W   = $clog2(K_MAX+1);
  localparam int ROW_W = idx_w(ROWS);
  localparam int FL_W  = idx_w(ROWS+COLS);
  localparam logic [FL_W-1:0]  FL_LOAD  = FL_W'(ROWS+COLS-2);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS-1);

  sa_state_t        r_state;
  sa_state_t        w_state_nxt;
  logic [K_W-1:0]   r_k_len;
  logic [K_W-1:0]   r_k_cnt;
  logic [FL_W-1:0]  r_flush_cnt;
  logic [ROW_W-1:0] r_out_row;
  logic             r_done;

  logic w_k_ok;
  logic w_start_ok;
  logic w_accept;
  logic w_k_last;
  logic w_shift;
  logic w_clr;
  logic w_out_hs;
  logic w_row_last;

  logic signed [DATA_W-1:0] w_inj_x [ROWS];
  logic signed [DATA_W-1:0] w_inj_w [COLS];
  logic signed [DATA_W-1:0] w_row_x [ROWS];
  logic                     w_row_v [ROWS];
  logic signed [DATA_W-1:0] w_col_w [COLS];

  logic signed [DATA_W-1:0] w_pe_x  [ROWS][COLS];
  logic                     w_pe_v  [ROWS][COLS];
  logic signed [DATA_W-1:0] w_pe_w  [ROWS][COLS];
  logic signed [ACC_W-1:0]  w_psum  [ROWS][COLS];

  assign w_k_ok     = (k_len != '0) && (k_len <= K_W'(K_MAX));
  assign w_start_ok = (r_state == IDLE) && start && w_k_ok;
  assign w_accept   = (r_state == STREAM) && in_valid;
  assign w_k_last   = ((r_k_cnt + K_W'(1)) == r_k_len);
  assign w_shift    = (r_state == STREAM) || (r_state == FLUSH);
  assign w_clr      = w_start_ok && !accumulate;
  assign w_out_hs   = (r_state == DRAIN) && out_ready;
  assign w_row_last = (r_out_row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_ok)               w_state_nxt = STREAM;
      STREAM:  if (w_accept && w_k_last)     w_state_nxt = FLUSH;
      FLUSH:   if (r_flush_cnt == '0)        w_state_nxt = DRAIN;
      DRAIN:   if (w_out_hs && w_row_last)   w_state_nxt = IDLE;
      default:                               w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE:    busy      = 1'b0;
      STREAM:  in_ready  = 1'b1;
      DRAIN:   out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_k_len     <= '0;
      r_k_cnt     <= '0;
      r_flush_cnt <= '0;
      r_out_row   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_out_hs && w_row_last;
      if (w_start_ok) begin
        r_k_len <= k_len;
        r_k_cnt <= '0;
      end else if (w_accept) begin
        r_k_cnt <= r_k_cnt + K_W'(1);
      end
      // Down-counter: terminal count 0 marks the last flush cycle.
      if (w_accept && w_k_last) begin
        r_flush_cnt <= FL_LOAD;
      end else if ((r_state == FLUSH) && (r_flush_cnt != '0)) begin
        r_flush_cnt <= r_flush_cnt - FL_W'(1);
      end
      if (w_out_hs) begin
        r_out_row <= w_row_last ? '0 : r_out_row + ROW_W'(1);
      end
    end
  end

  assign out_row = r_out_row;
  assign done    = r_done;

  // Non-accept cycles inject zero-operand bubbles with a cleared valid tag.
  for (genvar i = 0; i < ROWS; i++) begin : g_inj_x
    assign w_inj_x[i] = w_accept ? $signed(x_in[i*DATA_W +: DATA_W]) : '0;
  end
  for (genvar j = 0; j < COLS; j++) begin : g_inj_w
    assign w_inj_w[j] = w_accept ? $signed(w_in[j*DATA_W +: DATA_W]) : '0;
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row_skew
    if (i == 0) begin : g_direct
      assign w_row_x[i] = w_inj_x[i];
      assign w_row_v[i] = w_accept;
    end else begin : g_delay
      logic signed [DATA_W-1:0] r_dx [i];
      logic                     r_dv [i];
      always_ff @(posedge clk) begin
        if (!n_rst) begin
          for (int s = 0; s < i; s++) begin
            r_dx[s] <= '0;
            r_dv[s] <= 1'b0;
          end
        end else if (w_shift) begin
          r_dx[0] <= w_inj_x[i];
          r_dv[0] <= w_accept;
          for (int s = 1; s < i; s++) begin
            r_dx[s] <= r_dx[s-1];
            r_dv[s] <= r_dv[s-1];
          end
        end
      end
      assign w_row_x[i] = r_dx[i-1];
      assign w_row_v[i] = r_dv[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_col_skew
    if (j == 0) begin : g_direct
      assign w_col_w[j] = w_inj_w[j];
    end else begin : g_delay
      logic signed [DATA_W-1:0] r_dw [j];
      always_ff @(posedge clk) begin
        if (!n_rst) begin
          for (int s = 0; s < j; s++) begin
            r_dw[s] <= '0;
          end
        end else if (w_shift) begin
          r_dw[0] <= w_inj_w[j];
          for (int s = 1; s < j; s++) begin
            r_dw[s] <= r_dw[s-1];
          end
        end
      end
      assign w_col_w[j] = r_dw[j-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_pe_row
    for (genvar j = 0; j < COLS; j++) begin : g_pe_col
      logic signed [DATA_W-1:0] w_x_l;
      logic                     w_v_l;
      logic signed [DATA_W-1:0] w_w_t;
      if (j == 0) begin : g_x_edge
        assign w_x_l = w_row_x[i];
        assign w_v_l = w_row_v[i];
      end else begin : g_x_int
        assign w_x_l = w_pe_x[i][j-1];
        assign w_v_l = w_pe_v[i][j-1];
      end
      if (i == 0) begin : g_w_edge
        assign w_w_t = w_col_w[j];
      end else begin : g_w_int
        assign w_w_t = w_pe_w[i-1][j];
      end
      mac_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_en    (w_shift),
        .i_clr   (w_clr),
        .i_x     (w_x_l),
        .i_w     (w_w_t),
        .i_valid (w_v_l),
        .o_x     (w_pe_x[i][j]),
        .o_w     (w_pe_w[i][j]),
        .o_valid (w_pe_v[i][j]),
        .o_psum  (w_psum[i][j])
      );
    end
  end

  // Pass-through outputs on the right and bottom edges have no consumer.
  logic w_unused_edge;
  always_comb begin
    w_unused_edge = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      w_unused_edge = w_unused_edge ^ (^w_pe_x[i][COLS-1]) ^ w_pe_v[i][COLS-1];
    end
    for (int j = 0; j < COLS; j++) begin
      w_unused_edge = w_unused_edge ^ (^w_pe_w[ROWS-1][j]);
    end
  end

  always_comb begin
    y_out = '0;
    for (int j = 0; j < COLS; j++) begin
      y_out[j*ACC_W +: ACC_W] = w_psum[r_out_row][j];
    end
  end

endmodule
